nbody_pair_scheduler: RTL

- Sequences the all-pairs force sweep of the n-body engine: generates (i, j) body-address pairs for the position/mass RAMs and the getAccl pipeline, skipping self-pairs.
- Carries per-pair tags (first/last/i) through a delay line matched to pipeline latency, so the downstream accumulator and velocity write-back know when a body's sum is complete.
- Sits between the top-level go/done handshake and the RAM/getAccl datapath; one sweep per start.

---
 rtl/nbody_pair_scheduler.sv | 127 ++++++++++++
 1 files changed

// File: rtl/nbody_pair_scheduler.sv
// nbody_pair_scheduler: all-pairs (i,j) issue sequencer with pipeline-matched result tags.
// Optional perf counters (perf_cycles, perf_holds) enabled by defining NBODY_SCHED_PERF_EN.
module nbody_pair_scheduler #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int PIPE_LAT        = 61
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  input  logic                       hold,
  output logic                       busy,
  output logic                       done,
  output logic [BODY_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [BODY_ADDR_WIDTH-1:0] rd_addr_j,
  output logic                       issue_valid,
  output logic                       res_valid,
  output logic                       res_first,
  output logic                       res_last,
  output logic [BODY_ADDR_WIDTH-1:0] res_i
`ifdef NBODY_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_cycles,
  output logic [31:0]                perf_holds
`endif
);
  localparam int AW = BODY_ADDR_WIDTH;
  localparam int NW = AW + 1;
  localparam int TW = AW + 3;
  localparam int CW = PIPE_LAT > 1 ? $clog2(PIPE_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] i_q, i_d, j_q, j_d, j_inc;
  logic [NW-1:0] n_q, n_d, n_in, last_j;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PIPE_LAT-1:0][TW-1:0] dl_q, dl_d;
  logic last_i, j_end, first_j;
  always_comb begin
    n_in        = num_bodies > NW'(BODIES) ? NW'(BODIES) : num_bodies;
    last_i      = {1'b0, i_q} == n_q - NW'(1);
    last_j      = last_i ? n_q - NW'(2) : n_q - NW'(1);
    j_end       = {1'b0, j_q} == last_j;
    first_j     = j_q == AW'(i_q == '0);
    j_inc       = j_q + AW'(1);
    busy        = state_q == ISSUE || state_q == DRAIN;
    done        = state_q == DONE;
    issue_valid = state_q == ISSUE && !hold;
    rd_addr_i   = i_q;
    rd_addr_j   = j_q;
    {res_valid, res_first, res_last, res_i} = dl_q[PIPE_LAT-1];
  end
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        n_d     = n_in;
        i_d     = '0;
        j_d     = AW'(1);
        state_d = n_in >= NW'(2) ? ISSUE : DONE;
      end
      ISSUE: if (!hold) begin
        // skip the self-pair by stepping over j == i
        j_d = j_end ? '0 : (j_inc == i_q ? j_q + AW'(2) : j_inc);
        i_d = j_end && !last_i ? i_q + AW'(1) : i_q;
        if (j_end && last_i) begin
          j_d     = j_q;
          state_d = DRAIN;
          cnt_d   = CW'(PIPE_LAT - 1);
        end
      end
      DRAIN: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? DONE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  always_comb begin
    dl_d = '0;
    if (!abort) begin
      dl_d[0] = {issue_valid, first_j, j_end, i_q};
      for (int k = 1; k < PIPE_LAT; k++) dl_d[k] = dl_q[k-1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      dl_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      dl_q    <= dl_d;
    end
`ifdef NBODY_SCHED_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d, perf_holds_q, perf_holds_d;
  logic        accept;
  always_comb begin
    accept        = state_q == IDLE && start && !abort;
    perf_cycles_d = accept ? '0 : perf_cycles_q + 32'(busy && ~&perf_cycles_q);
    perf_holds_d  = accept ? '0 : perf_holds_q + 32'(state_q == ISSUE && hold && ~&perf_holds_q);
    perf_cycles   = perf_cycles_q;
    perf_holds    = perf_holds_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_cycles_q <= '0;
      perf_holds_q  <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_holds_q  <= perf_holds_d;
    end
`endif
endmodule
